// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Optional feature macro: FETCH_TIMEOUT_EN (memory timeout counter and FAULT state).
package fetch_pkg;

    localparam int              ADDR_W_DEF         = 16;
    localparam int              DATA_W_DEF         = 16;
    localparam int              PC_INC_DEF         = 2;
    localparam logic [15:0]     RESET_PC_DEF       = 16'h0000;
    localparam int              TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter: async reset to RESET_PC, parallel load, and a wrapping
// increment by PC_INC. Load has priority over increment.
module pc_register
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                PC_INC   = PC_INC_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load_s,
    input  logic [ADDR_W-1:0] load_val_s,
    input  logic              inc_s,
    output logic [ADDR_W-1:0] pc_r
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

    // PC update: redirect load first, otherwise step (wraps at 2^ADDR_W), otherwise hold
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_r <= RESET_PC;
        end else if (load_s) begin
            pc_r <= load_val_s;
        end else if (inc_s) begin
            pc_r <= pc_r + PC_STEP;
        end else begin
            pc_r <= pc_r;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs the memory read handshake and
// hands each fetched word to the instruction register with a one-cycle strobe.
// Optional feature macro: FETCH_TIMEOUT_EN adds a REQ timeout counter and a
// sticky FAULT state; without it FetchErr is tied low and REQ waits forever.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                PC_INC   = PC_INC_DEF
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int                TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FetchReq,
    input  logic              Stall,
    input  logic              BranchValid,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    input  logic              MemReady,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] InstOut,
    output logic              InstWrite,
    output logic              FetchDone,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              FetchErr
);

    fetch_state_e      state_r;
    logic [DATA_W-1:0] inst_out_r;
    logic              inst_write_r;
    logic              fetch_done_r;
    logic              mem_read_r;
    logic              busy_r;
    logic              pend_r;
    logic [ADDR_W-1:0] pend_tgt_r;
    logic [ADDR_W-1:0] pc_s;
    logic              pc_load_s;
    logic [ADDR_W-1:0] pc_load_val_s;
    logic              pc_inc_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    logic [CNT_W-1:0]          timeout_cnt_r;
    logic                      fetch_err_r;
`endif

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .load_s     (pc_load_s),
        .load_val_s (pc_load_val_s),
        .inc_s      (pc_inc_s),
        .pc_r       (pc_s)
    );

    // PC control: IDLE/WRITE take a live branch, REQ applies the pending redirect (newest target wins)
    always_comb begin
        pc_load_s     = 1'b0;
        pc_load_val_s = BranchTarget;
        pc_inc_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (BranchValid) begin
                    pc_load_s = 1'b1;
                end else begin
                    pc_load_s = 1'b0;
                end
            end
            REQ: begin
                if (pend_r) begin
                    pc_load_s     = 1'b1;
                    pc_load_val_s = BranchValid ? BranchTarget : pend_tgt_r;
                end else begin
                    pc_load_s = 1'b0;
                end
            end
            WRITE: begin
                if (BranchValid) begin
                    pc_load_s = 1'b1;
                end else begin
                    pc_inc_s = 1'b1;
                end
            end
            default: begin
                pc_load_s = 1'b0;
                pc_inc_s  = 1'b0;
            end
        endcase
    end

    // Fetch FSM with registered handshake outputs, pending redirect and captured instruction
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r       <= IDLE;
            inst_out_r    <= '0;
            inst_write_r  <= 1'b0;
            fetch_done_r  <= 1'b0;
            mem_read_r    <= 1'b0;
            busy_r        <= 1'b0;
            pend_r        <= 1'b0;
            pend_tgt_r    <= '0;
`ifdef FETCH_TIMEOUT_EN
            timeout_cnt_r <= '0;
            fetch_err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    inst_write_r <= 1'b0;
                    fetch_done_r <= 1'b0;
                    pend_r       <= 1'b0;
                    if (BranchValid) begin
                        // redirect wins; a still-high FetchReq starts the fetch next cycle
                        state_r    <= IDLE;
                        mem_read_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end else if (FetchReq && !Stall) begin
                        state_r       <= REQ;
                        mem_read_r    <= 1'b1;
                        busy_r        <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        timeout_cnt_r <= '0;
`endif
                    end else begin
                        state_r    <= IDLE;
                        mem_read_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                REQ: begin
                    if (pend_r) begin
                        // abandon this fetch; PC takes the redirect target
                        state_r    <= IDLE;
                        mem_read_r <= 1'b0;
                        busy_r     <= 1'b0;
                        pend_r     <= 1'b0;
                    end else if (BranchValid) begin
                        // any data returned now belongs to a dead path and is dropped
                        pend_r     <= 1'b1;
                        pend_tgt_r <= BranchTarget;
                    end else if (MemReady) begin
                        state_r      <= WRITE;
                        inst_out_r   <= MemData;
                        mem_read_r   <= 1'b0;
                        inst_write_r <= 1'b1;
                        fetch_done_r <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    end else if (timeout_cnt_r == CNT_LAST) begin
                        state_r     <= FAULT;
                        mem_read_r  <= 1'b0;
                        fetch_err_r <= 1'b1;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + CNT_ONE;
                    end
`else
                    end else begin
                        state_r <= REQ;
                    end
`endif
                end
                WRITE: begin
                    state_r      <= IDLE;
                    inst_write_r <= 1'b0;
                    fetch_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
                FAULT: begin
`ifdef FETCH_TIMEOUT_EN
                    // sticky until reset
                    state_r     <= FAULT;
                    mem_read_r  <= 1'b0;
                    busy_r      <= 1'b1;
                    fetch_err_r <= 1'b1;
`else
                    state_r    <= IDLE;
                    mem_read_r <= 1'b0;
                    busy_r     <= 1'b0;
`endif
                end
                default: begin
                    state_r      <= IDLE;
                    mem_read_r   <= 1'b0;
                    busy_r       <= 1'b0;
                    inst_write_r <= 1'b0;
                    fetch_done_r <= 1'b0;
                    pend_r       <= 1'b0;
                end
            endcase
        end
    end

    assign MemAddr   = pc_s;
    assign PC        = pc_s;
    assign MemRead   = mem_read_r;
    assign InstOut   = inst_out_r;
    assign InstWrite = inst_write_r;
    assign FetchDone = fetch_done_r;
    assign Busy      = busy_r;
`ifdef FETCH_TIMEOUT_EN
    assign FetchErr  = fetch_err_r;
`else
    assign FetchErr  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
// With FETCH_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=4.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        FetchReq;
    logic        Stall;
    logic        BranchValid;
    logic [15:0] BranchTarget;
    logic [15:0] MemAddr;
    logic        MemRead;
    logic        MemReady;
    logic [15:0] MemData;
    logic [15:0] InstOut;
    logic        InstWrite;
    logic        FetchDone;
    logic [15:0] PC;
    logic        Busy;
    logic        FetchErr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef FETCH_TIMEOUT_EN
    instruction_fetch_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
    instruction_fetch_unit dut (
`endif
        .CLK          (CLK),
        .RST_N        (RST_N),
        .FetchReq     (FetchReq),
        .Stall        (Stall),
        .BranchValid  (BranchValid),
        .BranchTarget (BranchTarget),
        .MemAddr      (MemAddr),
        .MemRead      (MemRead),
        .MemReady     (MemReady),
        .MemData      (MemData),
        .InstOut      (InstOut),
        .InstWrite    (InstWrite),
        .FetchDone    (FetchDone),
        .PC           (PC),
        .Busy         (Busy),
        .FetchErr     (FetchErr)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
    endtask

    // one complete fetch from IDLE with a given number of memory wait cycles
    task automatic fetchOne(input logic [15:0] data, input int waits,
                            input logic [15:0] addr, output int wrCyc);
        FetchReq = 1'b1;
        MemReady = 1'b0;
        MemData  = data;
        tick();
        checkVal("fo_memread", MemRead, 1);
        checkVal("fo_addr", MemAddr, addr);
        FetchReq = 1'b0;
        for (int w = 0; w < waits; w++) begin
            tick();
            checkVal("fo_wait_nowrite", InstWrite, 0);
        end
        MemReady = 1'b1;
        tick();
        checkVal("fo_instwrite", InstWrite, 1);
        checkVal("fo_instout", InstOut, data);
        wrCyc = cyc;
        MemReady = 1'b0;
        tick();
        checkVal("fo_strobe_end", InstWrite, 0);
    endtask

    logic [15:0] b2bData [3];
    int          wrAt    [3];

    initial begin
        b2bData[0] = 16'hCCCA;
        b2bData[1] = 16'h1234;
        b2bData[2] = 16'hABCD;
        RST_N = 1'b0; FetchReq = 1'b0; Stall = 1'b0; BranchValid = 1'b0;
        BranchTarget = 16'h0000; MemReady = 1'b0; MemData = 16'h0000;
        tick();
        tick();
        // reset values
        checkVal("rst_pc", PC, 16'h0000);
        checkVal("rst_instout", InstOut, 16'h0000);
        checkVal("rst_instwrite", InstWrite, 0);
        checkVal("rst_fetchdone", FetchDone, 0);
        checkVal("rst_memread", MemRead, 0);
        checkVal("rst_busy", Busy, 0);
        checkVal("rst_fetcherr", FetchErr, 0);
        RST_N = 1'b1;

        // single fetch with memory always ready
        MemReady = 1'b1; MemData = 16'hF0F0; FetchReq = 1'b1;
        tick();
        checkVal("t1_memread", MemRead, 1);
        checkVal("t1_addr", MemAddr, 16'h0000);
        checkVal("t1_busy", Busy, 1);
        checkVal("t1_nowrite", InstWrite, 0);
        FetchReq = 1'b0;
        tick();
        checkVal("t1_write", InstWrite, 1);
        checkVal("t1_done", FetchDone, 1);
        checkVal("t1_instout", InstOut, 16'hF0F0);
        checkVal("t1_memread_off", MemRead, 0);
        tick();
        checkVal("t1_write_off", InstWrite, 0);
        checkVal("t1_done_off", FetchDone, 0);
        checkVal("t1_pc", PC, 16'h0002);
        checkVal("t1_busy_off", Busy, 0);
        MemReady = 1'b0;
        tick();
        checkVal("t1_hold", InstOut, 16'hF0F0);

        // back-to-back fetches, two wait cycles each
        doReset();
        for (int i = 0; i < 3; i++) begin
            fetchOne(b2bData[i], 2, 16'(2 * i), wrAt[i]);
        end
        checkVal("b2b_gap1", wrAt[1] - wrAt[0], 5);
        checkVal("b2b_gap2", wrAt[2] - wrAt[1], 5);
        checkVal("b2b_pc", PC, 16'h0006);

        // redirect while in REQ drops the fetch
        FetchReq = 1'b1;
        tick();
        checkVal("brq_addr", MemAddr, 16'h0006);
        FetchReq = 1'b0;
        BranchValid = 1'b1; BranchTarget = 16'h0040;
        tick();
        checkVal("brq_still_req", MemRead, 1);
        BranchValid = 1'b0;
        MemReady = 1'b1; MemData = 16'hDEAD;
        tick();
        checkVal("brq_nowrite", InstWrite, 0);
        checkVal("brq_memread_off", MemRead, 0);
        checkVal("brq_pc", PC, 16'h0040);
        MemReady = 1'b0;
        tick();
        checkVal("brq_nowrite2", InstWrite, 0);
        checkVal("brq_instout", InstOut, 16'hABCD);
        fetchOne(16'h1111, 0, 16'h0040, wrAt[0]);
        checkVal("brq_next_pc", PC, 16'h0042);

        // redirect during WRITE keeps the write and replaces the increment
        FetchReq = 1'b1; MemData = 16'h2222;
        tick();
        FetchReq = 1'b0; MemReady = 1'b1;
        tick();
        checkVal("bwr_write", InstWrite, 1);
        MemReady = 1'b0; BranchValid = 1'b1; BranchTarget = 16'h0100;
        tick();
        BranchValid = 1'b0;
        checkVal("bwr_pc", PC, 16'h0100);
        checkVal("bwr_instout", InstOut, 16'h2222);

        // branch in IDLE beats FetchReq, then PC wraps at top of memory
        BranchValid = 1'b1; BranchTarget = 16'hFFFE; FetchReq = 1'b1;
        tick();
        BranchValid = 1'b0;
        checkVal("wrap_pc_load", PC, 16'hFFFE);
        checkVal("wrap_branch_wins", MemRead, 0);
        tick();
        checkVal("wrap_memread", MemRead, 1);
        checkVal("wrap_addr", MemAddr, 16'hFFFE);
        FetchReq = 1'b0; MemReady = 1'b1; MemData = 16'h5A5A;
        tick();
        MemReady = 1'b0;
        tick();
        checkVal("wrap_pc", PC, 16'h0000);

        // Stall blocks the start of a fetch
        Stall = 1'b1; FetchReq = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            checkVal("stall_memread", MemRead, 0);
        end
        Stall = 1'b0;
        tick();
        checkVal("stall_release", MemRead, 1);
        FetchReq = 1'b0; MemReady = 1'b1; MemData = 16'h7777;
        tick();
        checkVal("stall_instout", InstOut, 16'h7777);
        MemReady = 1'b0;
        tick();
        checkVal("stall_pc", PC, 16'h0002);

        // memory never answers
        FetchReq = 1'b1; MemReady = 1'b0;
        tick();
        FetchReq = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int t = 0; t < 3; t++) begin
            tick();
            checkVal("to_noerr", FetchErr, 0);
        end
        tick();
        checkVal("to_err", FetchErr, 1);
        checkVal("to_memread", MemRead, 0);
        checkVal("to_busy", Busy, 1);
        FetchReq = 1'b1; BranchValid = 1'b1; BranchTarget = 16'h0200;
        tick();
        FetchReq = 1'b0; BranchValid = 1'b0;
        checkVal("to_pc_ignored", PC, 16'h0002);
        checkVal("to_sticky", FetchErr, 1);
`else
        repeat (10) tick();
        checkVal("nto_err", FetchErr, 0);
        checkVal("nto_memread", MemRead, 1);
`endif
        doReset();
        checkVal("post_rst_err", FetchErr, 0);

        // asynchronous reset in the middle of REQ
        FetchReq = 1'b1;
        tick();
        FetchReq = 1'b0;
        checkVal("ar_req", MemRead, 1);
        #2;
        RST_N = 1'b0;
        #1;
        checkVal("ar_memread", MemRead, 0);
        checkVal("ar_busy", Busy, 0);
        checkVal("ar_instout", InstOut, 16'h0000);
        checkVal("ar_pc", PC, 16'h0000);
        MemReady = 1'b1; MemData = 16'h9999;
        tick();
        checkVal("ar_nowrite", InstWrite, 0);
        RST_N = 1'b1;
        tick();
        checkVal("ar_nowrite2", InstWrite, 0);
        checkVal("ar_idle", MemRead, 0);
        MemReady = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
